// File: rtl/inverter_bank_if.sv
// Bus bundle for inverter_bank: data input, combinational and registered
// outputs, invert-mask programming and activity-counter observation.
// Optional macro INVERTER_BANK_PARITY_EN adds the y_par signal.
interface inverter_bank_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic             mask_we;
  logic [WIDTH-1:0] mask_wdata;
  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] act_cnt;
  logic             act_clr;
`ifdef INVERTER_BANK_PARITY_EN
  logic             y_par;

  modport master (
    output a, in_valid, mask_we, mask_wdata, act_clr,
    input  y, y_q, out_valid, mask, act_cnt, y_par
  );

  modport slave (
    input  a, in_valid, mask_we, mask_wdata, act_clr,
    output y, y_q, out_valid, mask, act_cnt, y_par
  );
`else
  modport master (
    output a, in_valid, mask_we, mask_wdata, act_clr,
    input  y, y_q, out_valid, mask, act_cnt
  );

  modport slave (
    input  a, in_valid, mask_we, mask_wdata, act_clr,
    output y, y_q, out_valid, mask, act_cnt
  );
`endif
endinterface

// File: rtl/inverter_bank.sv
// inverter_bank: per-bit programmable inverter with a combinational output,
// a valid-qualified registered output and a saturating activity counter.
// After reset the mask is all ones, so the block is a plain inverter.
// Optional macro INVERTER_BANK_PARITY_EN adds a registered parity bit y_par.
module inverter_bank #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  inverter_bank_if.slave bus
);

  // Even-parity helper: XOR reduction of a data word.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_q_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] act_cnt_r;
  logic             cnt_inc_s;

  // Combinational data path; uses the mask currently held, never reset.
  always_comb begin
    y_s = bus.a ^ mask_r;
  end

  // Counter step qualifier: accepted word that changes y_q, not yet saturated.
  always_comb begin
    cnt_inc_s = 1'b0;
    if (bus.in_valid && (y_s != y_q_r) && (act_cnt_r != {CNT_W{1'b1}})) begin
      cnt_inc_s = 1'b1;
    end else begin
      cnt_inc_s = 1'b0;
    end
  end

  // Invert-mask register; a same-cycle write only takes effect after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r <= {WIDTH{1'b1}};
    end else if (bus.mask_we) begin
      mask_r <= bus.mask_wdata;
    end else begin
      mask_r <= mask_r;
    end
  end

  // Registered output path: capture on in_valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      y_q_r       <= y_s;
      out_valid_r <= 1'b1;
    end else begin
      y_q_r       <= y_q_r;
      out_valid_r <= 1'b0;
    end
  end

  // Activity counter: clear beats increment, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.act_clr) begin
      act_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      act_cnt_r <= act_cnt_r + CNT_W'(1);
    end else begin
      act_cnt_r <= act_cnt_r;
    end
  end

`ifdef INVERTER_BANK_PARITY_EN
  logic y_par_r;

  // Parity of each accepted word, registered alongside y_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_par_r <= 1'b0;
    end else if (bus.in_valid) begin
      y_par_r <= parity_f(y_s);
    end else begin
      y_par_r <= y_par_r;
    end
  end

  assign bus.y_par = y_par_r;
`endif

  assign bus.y         = y_s;
  assign bus.y_q       = y_q_r;
  assign bus.out_valid = out_valid_r;
  assign bus.mask      = mask_r;
  assign bus.act_cnt   = act_cnt_r;

endmodule

// File: tb/tb_inverter_bank.sv
// Testbench for inverter_bank: two 1-bit instances driven with opposite
// values plus an 8-bit instance compared every cycle against a reference
// model built from the behavioural rules.
module tb_inverter_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inverter_bank_if #(.WIDTH(1), .CNT_W(8)) b1a ();
  inverter_bank_if #(.WIDTH(1), .CNT_W(8)) b1b ();
  inverter_bank_if #(.WIDTH(8), .CNT_W(8)) b8 ();

  inverter_bank #(.WIDTH(1), .CNT_W(8)) u_inv1a (.clk(clk), .rst(rst), .bus(b1a));
  inverter_bank #(.WIDTH(1), .CNT_W(8)) u_inv1b (.clk(clk), .rst(rst), .bus(b1b));
  inverter_bank #(.WIDTH(8), .CNT_W(8)) u_inv8  (.clk(clk), .rst(rst), .bus(b8));

  int checks   = 0;
  int failures = 0;

  // Reference state of the 8-bit instance.
  logic [7:0] m_mask;
  logic [7:0] m_yq;
  logic       m_ov;
  int         m_cnt;
  logic       m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Compare every 8-bit output against the model.
  task automatic check_all(input string tag);
    check({tag, ".y"},         {24'd0, b8.y},         {24'd0, b8.a ^ m_mask});
    check({tag, ".y_q"},       {24'd0, b8.y_q},       {24'd0, m_yq});
    check({tag, ".out_valid"}, {31'd0, b8.out_valid}, {31'd0, m_ov});
    check({tag, ".mask"},      {24'd0, b8.mask},      {24'd0, m_mask});
    check({tag, ".act_cnt"},   {24'd0, b8.act_cnt},   m_cnt);
`ifdef INVERTER_BANK_PARITY_EN
    check({tag, ".y_par"},     {31'd0, b8.y_par},     {31'd0, m_par});
`endif
  endtask

  // Advance one clock: predict from the inputs now applied, then compare.
  task automatic tick(input string tag);
    logic [7:0] nv;
    logic [7:0] n_mask;
    logic [7:0] n_yq;
    logic       n_ov;
    int         n_cnt;
    logic       n_par;
    nv     = b8.a ^ m_mask;
    n_mask = m_mask;
    n_yq   = m_yq;
    n_ov   = 1'b0;
    n_cnt  = m_cnt;
    n_par  = m_par;
    if (rst) begin
      n_mask = 8'hFF;
      n_yq   = 8'h00;
      n_cnt  = 0;
      n_par  = 1'b0;
    end else begin
      if (b8.in_valid && nv != m_yq) n_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      if (b8.act_clr) n_cnt = 0;
      if (b8.in_valid) begin
        n_yq  = nv;
        n_ov  = 1'b1;
        n_par = ^nv;
      end
      if (b8.mask_we) n_mask = b8.mask_wdata;
    end
    @(posedge clk);
    #1;
    m_mask = n_mask;
    m_yq   = n_yq;
    m_ov   = n_ov;
    m_cnt  = n_cnt;
    m_par  = n_par;
    check_all(tag);
  endtask

  task automatic drive8(input logic [7:0] a, input logic iv, input logic we,
                        input logic [7:0] wd, input logic clr);
    b8.a = a; b8.in_valid = iv; b8.mask_we = we; b8.mask_wdata = wd; b8.act_clr = clr;
  endtask

  initial begin
    rst = 1'b1;
    b1a.a = 1'b0; b1a.in_valid = 1'b0; b1a.mask_we = 1'b0; b1a.mask_wdata = 1'b0; b1a.act_clr = 1'b0;
    b1b.a = 1'b1; b1b.in_valid = 1'b0; b1b.mask_we = 1'b0; b1b.mask_wdata = 1'b0; b1b.act_clr = 1'b0;
    drive8(8'h5A, 1'b1, 1'b1, 8'h12, 1'b1);
    m_mask = 8'hFF; m_yq = 8'h00; m_ov = 1'b0; m_cnt = 0; m_par = 1'b0;

    // Reset state; mask/valid/clear are ignored while rst is high.
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    drive8(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    check("reset.y_is_not_a", {24'd0, b8.y}, 32'hFF);

    // 1-bit pair: default inversion, opposite drives stay opposite.
    b1a.a = 1'b0; b1b.a = 1'b1; #1;
    check("w1.a0", {31'd0, b1a.y}, 32'd1);
    check("w1.b1", {31'd0, b1b.y}, 32'd0);
    check("w1.opp0", {31'd0, b1a.y ^ b1b.y}, 32'd1);
    b1a.a = 1'b1; b1b.a = 1'b0; #1;
    check("w1.a1", {31'd0, b1a.y}, 32'd0);
    check("w1.b0", {31'd0, b1b.y}, 32'd1);
    check("w1.opp1", {31'd0, b1a.y ^ b1b.y}, 32'd1);

    // Single accepted word, then hold.
    drive8(8'h0F, 1'b1, 1'b0, 8'h00, 1'b0);
    tick("w8.accept");
    check("w8.yq_F0", {24'd0, b8.y_q}, 32'hF0);
    check("w8.ov1", {31'd0, b8.out_valid}, 32'd1);
    drive8(8'h33, 1'b0, 1'b0, 8'h00, 1'b0);
    tick("w8.idle");
    check("w8.hold_F0", {24'd0, b8.y_q}, 32'hF0);
    check("w8.ov0", {31'd0, b8.out_valid}, 32'd0);

    // Mask write in the same cycle as a word: old mask applies to that word.
    drive8(8'hAA, 1'b1, 1'b1, 8'h00, 1'b0);
    tick("mask.same");
    check("mask.old_55", {24'd0, b8.y_q}, 32'h55);
    check("mask.y_new", {24'd0, b8.y}, 32'hAA);
    drive8(8'hAA, 1'b1, 1'b0, 8'h00, 1'b0);
    tick("mask.next");
    check("mask.new_AA", {24'd0, b8.y_q}, 32'hAA);

    // Saturation: toggle a every cycle for 300 cycles.
    for (int i = 0; i < 300; i++) begin
      drive8((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
      tick("sat");
    end
    check("sat.255", {24'd0, b8.act_cnt}, 32'd255);
    drive8(8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    tick("clr");
    check("clr.zero", {24'd0, b8.act_cnt}, 32'd0);
    check("clr.changed", {24'd0, b8.y_q}, 32'h00);

    // Reset mid-stream with mask 00 and y_q 3C.
    drive8(8'h3C, 1'b1, 1'b1, 8'h00, 1'b0);
    tick("rst.prep0");
    drive8(8'h3C, 1'b1, 1'b0, 8'h00, 1'b0);
    tick("rst.prep1");
    check("rst.prep_3C", {24'd0, b8.y_q}, 32'h3C);
    rst = 1'b1;
    drive8(8'hC3, 1'b1, 1'b1, 8'h12, 1'b0);
    tick("rst.mid");
    check("rst.mask_FF", {24'd0, b8.mask}, 32'hFF);
    check("rst.yq_0", {24'd0, b8.y_q}, 32'h00);
    check("rst.ov_0", {31'd0, b8.out_valid}, 32'd0);
    check("rst.cnt_0", {24'd0, b8.act_cnt}, 32'd0);
    rst = 1'b0;

    // Parity / default-mask word.
    drive8(8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
    tick("par");
    check("par.yq_FE", {24'd0, b8.y_q}, 32'hFE);
`ifdef INVERTER_BANK_PARITY_EN
    check("par.bit1", {31'd0, b8.y_par}, 32'd1);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive8(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
             8'($urandom), ($urandom_range(0, 19) == 0));
      #1;
      check("rand.y_comb", {24'd0, b8.y}, {24'd0, b8.a ^ m_mask});
      tick("rand");
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inverter_bank.md
Name: inverter_bank

Overview:
- Parameterised bank of bit-wise inverters with a programmable per-bit invert mask.
- Provides two outputs: a combinational path (y) and a registered, valid-qualified path (y_q).
- Includes a saturating output-activity counter.
- Used as a polarity-correction stage between blocks. After reset it behaves as a plain inverter: y = ~a.

Parameters:
- WIDTH, 1, data width of a, y, y_q and mask.
- CNT_W, 8, width of the activity counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising clk.
- a  input  WIDTH  data input.
- y  output  WIDTH  combinational output, a XOR mask_r.
- in_valid  input  1  qualifies a for the registered path.
- y_q  output  WIDTH  registered output.
- out_valid  output  1  y_q holds new data this cycle.
- mask_we  input  1  write strobe for the invert mask.
- mask_wdata  input  WIDTH  new mask value; bit=1 inverts, bit=0 passes through.
- mask  output  WIDTH  current mask register value.
- act_cnt  output  CNT_W  count of registered-output changes, saturating.
- act_clr  input  1  synchronous clear of act_cnt.

Behaviour:
- Reset values:
  - mask_r = all ones, so the default function is pure inversion.
  - y_q = 0, out_valid = 0, act_cnt = 0.
  - y is combinational and not reset. During reset it still equals a ^ mask_r, i.e. ~a.
- Combinational path:
  - y = a ^ mask_r with zero latency; no clock involvement.
  - With the default mask, a=0 gives y=1 and a=1 gives y=0 for every bit.
  - X on a propagates to y.
- Registered path:
  - If in_valid=1 at a rising edge: y_q <= a ^ mask_r (mask value before any same-cycle write), and out_valid <= 1.
  - If in_valid=0: y_q holds and out_valid <= 0.
  - Latency is 1 cycle, throughput 1 word per cycle, no backpressure.
- Mask write:
  - mask_we=1 loads mask_wdata at the edge.
  - The new mask affects y from the next cycle and y_q from the next accepted word.
  - The same-cycle path uses the old mask.
- Activity counter:
  - Increments by 1 on each edge where in_valid=1 and the newly computed value differs from the current y_q.
  - Saturates at 2^CNT_W-1; no wrap.
  - act_clr=1 forces 0 and wins over an increment in the same cycle.
- Reset priority: rst wins over mask_we, in_valid and act_clr. A reset mid-stream drops the in-flight word: out_valid=0 on the next cycle.
- No internal state machine beyond these registers.

Optional Feature:
- Macro: INVERTER_BANK_PARITY_EN.
- When defined:
  - Adds output port y_par (1 bit), registered alongside y_q.
  - On each accepted word, y_par <= XOR-reduction of the new y_q value.
  - Reset value of y_par is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then with WIDTH=1: a=0 -> y=1; a=1 -> y=0, checked combinationally at t+0. Repeat on a second instance driven with opposite values simultaneously; its outputs must stay opposite to the first instance.
- WIDTH=8: in_valid=1 with a=8'h0F for one cycle -> next cycle y_q=8'hF0, out_valid=1. The following cycle in_valid=0 -> out_valid=0 and y_q holds 8'hF0.
- mask_we=1 with mask_wdata=8'h00, same cycle a=8'hAA and in_valid=1 -> y_q=8'h55 (old mask). Next word a=8'hAA -> y_q=8'hAA, and y=8'hAA combinationally.
- Alternate a between 0 and all ones with in_valid=1 for 300 cycles, CNT_W=8 -> act_cnt saturates at 255. Assert act_clr -> act_cnt=0 on the next cycle, even while a change occurs in that cycle.
- Assert rst mid-stream after mask=8'h00 and y_q=8'h3C -> next cycle mask=8'hFF, y_q=0, out_valid=0, act_cnt=0.
- With INVERTER_BANK_PARITY_EN defined: a=8'h01 accepted under the default mask -> y_q=8'hFE, y_par=1.
